// File: rtl/wc_pkg.sv
// Shared definitions for the wildcard nibble link.
package wc_pkg;
   localparam int NIBBLE_W = 4;

   typedef enum logic {WC_IDLE, WC_SEND} wc_tx_state_t;
endpackage

// File: rtl/wc_nibble_tx_if.sv
// Word input port and nibble output port of the nibble transmitter.
interface wc_nibble_tx_if #(parameter int NIBBLES = 4);
   import wc_pkg::*;

   logic                         word_valid;
   logic                         word_ready;
   logic [NIBBLE_W*NIBBLES-1:0]  word_data;
   logic                         word_last;
   logic                         data_valid;
   logic                         data_ready;
   logic [NIBBLE_W-1:0]          data_out;
   logic                         data_last;
   logic                         busy;

   modport master (
      output word_valid, word_data, word_last, data_ready,
      input  word_ready, data_valid, data_out, data_last, busy
   );

   modport slave (
      input  word_valid, word_data, word_last, data_ready,
      output word_ready, data_valid, data_out, data_last, busy
   );
endinterface

// File: rtl/wc_nibble_tx.sv
// Serializes valid/ready words into NIBBLES 4-bit beats, one per cycle, with
// back-to-back reload on the final beat; outputs come straight from registers.
module wc_nibble_tx
   import wc_pkg::*;
#(
   parameter int NIBBLES   = 4,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic          clk,
   input  logic          reset,
   wc_nibble_tx_if.slave bus
);
   localparam int W  = NIBBLE_W * NIBBLES;
   localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

   wc_tx_state_t  state_q, state_d;
   logic [W-1:0]  shift_q, shift_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          last_q,  last_d;

   logic send, at_last, word_fire, nib_fire;

   assign send      = (state_q == WC_SEND);
   assign at_last   = (cnt_q == CNT_LAST);
   // word_valid deliberately stays out of word_ready to avoid a valid->ready loop.
   assign bus.word_ready = !send || (at_last && bus.data_ready);
   assign word_fire = bus.word_valid && bus.word_ready;
   assign nib_fire  = send && bus.data_ready;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      if (word_fire) begin
         state_d = WC_SEND;
         shift_d = bus.word_data;
         last_d  = bus.word_last;
         cnt_d   = '0;
      end else if (nib_fire) begin
         if (at_last) begin
            state_d = WC_IDLE;
         end else begin
            shift_d = MSB_FIRST ? (shift_q << NIBBLE_W) : (shift_q >> NIBBLE_W);
            cnt_d   = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= WC_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   assign bus.data_valid = send;
   assign bus.busy       = send;
   assign bus.data_out   = MSB_FIRST ? shift_q[W-1 -: NIBBLE_W] : shift_q[NIBBLE_W-1:0];
   // Gated with send so a stale flag from a finished word never shows in IDLE.
   assign bus.data_last  = send && last_q && at_last;
endmodule
